rr_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters.
- Produces a registered one-hot grant vector plus its binary index, matching the one-hot/encoded format of the 8-to-3 encoder datapath.
- A grant is held while its requester keeps req high, and is released on req drop, disable, or hold timeout.
- Sits between requesting agents and the shared encoder/resource; drives its enable (gnt_valid) and select (gnt_idx).

---
 rtl/rr_grant_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with registered one-hot/encoded grant and hold timeout
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int CW   = IDX_W + 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
    localparam logic [N-1:0]     GNT_ONE   = N'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              tout_q, tout_d;

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [CW-1:0]     cand_w;
    logic [IDX_W-1:0]  cand;
    logic              rel_drop;
    logic              rel_tmo;
    logic [IDX_W-1:0]  ptr_next;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_w    = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand_w = {1'b0, ptr_q} + CW'(k);
            if (cand_w >= CW'(N)) begin
                cand_w = cand_w - CW'(N);
            end
            cand = cand_w[IDX_W-1:0];
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign rel_drop = !req[idx_q] || !en;
    assign rel_tmo  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign ptr_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && sel_found) begin
                    gnt_d   = GNT_ONE << sel_idx;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel_drop || rel_tmo) begin
                    gnt_d   = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    ptr_d   = ptr_next;
                    tout_d  = rel_tmo && !rel_drop;
                    state_d = IDLE;
                end else if ((MAX_HOLD != 0) && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = tout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter with timeout and no-timeout instances
module tb_rr_grant_arbiter;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int MH_A = 4;
    localparam int MH_B = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [N-1:0]  req = '0;

    logic [N-1:0]  gnt_a, gnt_b;
    logic [IW-1:0] idx_a, idx_b;
    logic          v_a, v_b, t_a, t_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N(N), .IDX_W(IW), .MAX_HOLD(MH_A)) u_a (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(v_a), .timeout(t_a)
    );

    rr_grant_arbiter #(.N(N), .IDX_W(IW), .MAX_HOLD(MH_B)) u_b (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(v_b), .timeout(t_b)
    );

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        logic          valid;
        logic          tout;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model: who owns the resource, how many cycles it has been visible, where the next search starts.
    int owner[2] = '{-1, -1};
    int age[2]   = '{0, 0};
    int start[2] = '{0, 0};
    int mh[2]    = '{MH_A, MH_B};

    function automatic exp_t model_step(int m, bit r, bit e, logic [N-1:0] rq);
        exp_t x;
        bit   tout;
        bit   drop;
        bit   expire;
        tout = 1'b0;
        if (r) begin
            owner[m] = -1;
            start[m] = 0;
            age[m]   = 0;
        end else if (owner[m] < 0) begin
            if (e) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (start[m] + k) % N;
                    if (rq[c]) begin
                        owner[m] = c;
                        age[m]   = 1;
                        break;
                    end
                end
            end
        end else begin
            drop   = !rq[owner[m]] || !e;
            expire = (mh[m] != 0) && (age[m] == mh[m]);
            if (drop || expire) begin
                start[m] = (owner[m] + 1) % N;
                owner[m] = -1;
                tout     = expire && !drop;
            end else begin
                age[m] = age[m] + 1;
            end
        end
        x.gnt = '0;
        if (owner[m] >= 0) x.gnt[owner[m]] = 1'b1;
        x.idx   = (owner[m] >= 0) ? IW'(owner[m]) : '0;
        x.valid = (owner[m] >= 0);
        x.tout  = tout;
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [N-1:0] rq);
        rst = r;
        en  = e;
        req = rq;
        q_a.push_back(model_step(0, r, e, rq));
        q_b.push_back(model_step(1, r, e, rq));
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expected result per clock and compares away from the edge.
    int run_a = 0;
    always @(negedge clk) begin
        exp_t ea, eb;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            cmp("a_gnt", 32'(gnt_a), 32'(ea.gnt));
            cmp("a_idx", 32'(idx_a), 32'(ea.idx));
            cmp("a_valid", 32'(v_a), 32'(ea.valid));
            cmp("a_timeout", 32'(t_a), 32'(ea.tout));
            if (v_a === 1'b1) begin
                run_a++;
                checks++;
                if (run_a > MH_A) begin
                    errors++;
                    $display("FAIL a_hold_len: got %0d cycles, limit %0d", run_a, MH_A);
                end
            end else begin
                run_a = 0;
            end
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            cmp("b_gnt", 32'(gnt_b), 32'(eb.gnt));
            cmp("b_idx", 32'(idx_b), 32'(eb.idx));
            cmp("b_valid", 32'(v_b), 32'(eb.valid));
            cmp("b_timeout", 32'(t_b), 32'(eb.tout));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] rq;
        bit           r, e;

        // Single request, grant latency and release pointer.
        step(1, 0, '0);
        step(1, 0, '0);
        step(0, 1, 8'h04);
        cmp("t1_gnt", 32'(gnt_a), 32'h04);
        cmp("t1_idx", 32'(idx_a), 32'd2);
        cmp("t1_valid", 32'(v_a), 32'd1);
        step(0, 1, 8'h04);
        step(0, 1, 8'h04);
        step(0, 1, 8'h00);
        cmp("t1_rel_valid", 32'(v_a), 32'd0);
        cmp("t1_rel_idx", 32'(idx_a), 32'd0);
        step(0, 1, 8'hFF);
        cmp("t1_ptr3", 32'(idx_a), 32'd3);

        // All requesting: rotation with MAX_HOLD timeout and one-cycle gaps.
        step(1, 0, '0);
        for (int i = 0; i < 46; i++) step(0, 1, 8'hFF);

        // Pointer wrap after idx 7.
        step(1, 0, '0);
        step(0, 1, 8'h80);
        cmp("t3_idx7", 32'(idx_a), 32'd7);
        step(0, 1, 8'h00);
        step(0, 1, 8'h81);
        cmp("t3_wrap_idx", 32'(idx_a), 32'd0);
        cmp("t3_wrap_gnt", 32'(gnt_a), 32'h01);

        // Enable drop mid-grant.
        step(1, 0, '0);
        step(0, 1, 8'h20);
        step(0, 1, 8'h20);
        step(0, 0, 8'hFF);
        cmp("t4_valid", 32'(v_a), 32'd0);
        cmp("t4_timeout", 32'(t_a), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'hFF);
            cmp("t4_blocked", 32'(v_a), 32'd0);
        end
        step(0, 1, 8'hFF);
        cmp("t4_ptr6", 32'(idx_a), 32'd6);

        // Reset mid-grant.
        step(1, 0, '0);
        step(0, 1, 8'h40);
        cmp("t5_idx6", 32'(idx_a), 32'd6);
        step(1, 1, 8'hFF);
        cmp("t5_rst_valid", 32'(v_a), 32'd0);
        step(0, 1, 8'hFF);
        cmp("t5_after_rst", 32'(idx_a), 32'd0);

        // Long hold: instance B never times out.
        step(1, 0, '0);
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 8'h20);
            cmp("t6_b_valid", 32'(v_b), 32'd1);
            cmp("t6_b_timeout", 32'(t_b), 32'd0);
        end

        // Random traffic.
        step(1, 0, '0);
        rq = '0;
        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 3) rq = N'($urandom());
            if ($urandom_range(0, 19) == 0) rq = '0;
            step(r, e, rq);
        end

        #5;
        cmp("drain_a", 32'(q_a.size()), 32'd0);
        cmp("drain_b", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
